// File: rtl/iomem_rng_fifo_if.sv
// Bus bundle for the picosoc iomem port of the RNG FIFO slave.
// The CPU side (master) drives the request and the slave returns select, ready and read data.
interface iomem_rng_fifo_if;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic        iomem_sel;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_sel, iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_sel, iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/iomem_rng_fifo.sv
// iomem slave buffering RNG words in a FIFO, with status/control/seed registers and blocking reads.
// Optional feature: define RNGFIFO_HEALTH_EN to discard repeated RNG words and count them in STATUS[19:12].
module iomem_rng_fifo #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_1000,
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 16,
    parameter int          TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    iomem_rng_fifo_if.slave   bus,
    output logic              rng_re_o,
    output logic              rng_we_o,
    output logic [DATA_W-1:0] rng_di_o,
    input  logic [DATA_W-1:0] rng_do_i,
    input  logic              rng_wait_i
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RESP, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
    logic               fill_en_q, fill_en_d, blocking_q, blocking_d, uf_q, uf_d;
    logic               ready_q, ready_d, rng_re_q, rng_re_d, rng_we_q, rng_we_d;
    logic [31:0]        rdata_q, rdata_d, status, head_word, seed32, wmask;
    logic [DATA_W-1:0]  rng_di_q, rng_di_d;
    logic               empty, full, push, push_ok, pop, flush, set_uf, clr_uf, wr;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    assign bus.iomem_sel   = bus.iomem_valid && (bus.iomem_addr[31:4] == BASE_ADDR[31:4]);
    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign rng_re_o        = rng_re_q;
    assign rng_we_o        = rng_we_q;
    assign rng_di_o        = rng_di_q;

    assign level_q = wptr_q - rptr_q;
    assign empty   = (level_q == '0);
    assign full    = (level_q == PTR_W'(DEPTH));
    assign wr      = |bus.iomem_wstrb;
    assign push_ok = rng_re_q && !rng_wait_i;

`ifdef RNGFIFO_HEALTH_EN
    logic [DATA_W-1:0] last_q;
    logic              last_valid_q, repeat_hit;
    logic [7:0]        rep_q, rep_d;

    assign repeat_hit = push_ok && last_valid_q && (rng_do_i == last_q);
    assign push       = push_ok && !repeat_hit;

    always_comb begin
        rep_d = rep_q;
        if (clr_uf)
            rep_d = '0;
        else if (repeat_hit && rep_q != 8'hFF)
            rep_d = rep_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q       <= '0;
            last_valid_q <= 1'b0;
            rep_q        <= '0;
        end else begin
            rep_q <= rep_d;
            if (push) begin
                last_q       <= rng_do_i;
                last_valid_q <= 1'b1;
            end
        end
    end
`else
    assign push = push_ok;
`endif

    always_comb begin
        status       = '0;
        status[7:0]  = 8'(level_q);
        status[8]    = empty;
        status[9]    = full;
        status[10]   = uf_q;
`ifdef RNGFIFO_HEALTH_EN
        status[19:12] = rep_q;
`endif
        head_word               = '0;
        head_word[DATA_W-1:0]   = mem_q[rptr_q[AW-1:0]];
        wmask  = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}},
                  {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};
        seed32 = bus.iomem_wdata & wmask;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = '0;
        fill_en_d  = fill_en_q;
        blocking_d = blocking_q;
        rng_we_d   = 1'b0;
        rng_di_d   = rng_di_q;
        pop        = 1'b0;
        flush      = 1'b0;
        set_uf     = 1'b0;
        clr_uf     = 1'b0;
        case (state_q)
            S_IDLE: if (bus.iomem_sel && !ready_q) begin
                state_d = S_RESP;
                case (bus.iomem_addr[3:2])
                    2'd0: if (!wr) begin
                        if (!empty) begin
                            pop     = 1'b1;
                            rdata_d = head_word;
                        end else if (blocking_q) begin
                            state_d = S_WAIT;
                            cnt_d   = '0;
                        end else begin
                            rdata_d = '1;
                            set_uf  = 1'b1;
                        end
                    end
                    2'd1: rdata_d = status;
                    2'd2: begin
                        rdata_d = {30'd0, blocking_q, fill_en_q};
                        if (bus.iomem_wstrb[0]) begin
                            fill_en_d  = bus.iomem_wdata[0];
                            blocking_d = bus.iomem_wdata[1];
                            flush      = bus.iomem_wdata[2];
                            clr_uf     = bus.iomem_wdata[3];
                        end
                    end
                    default: if (wr) begin
                        rng_we_d = 1'b1;
                        rng_di_d = seed32[DATA_W-1:0];
                        flush    = 1'b1;
                    end
                endcase
            end
            S_WAIT: begin
                if (!empty) begin
                    pop     = 1'b1;
                    rdata_d = head_word;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    rdata_d = '1;
                    set_uf  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_RESP);
        uf_d    = set_uf || (uf_q && !clr_uf);
        // A flush overrides any coincident push or pop.
        wptr_d   = flush ? '0 : wptr_q + PTR_W'(push);
        rptr_d   = flush ? '0 : rptr_q + PTR_W'(pop);
        level_d  = wptr_d - rptr_d;
        // Registered look-ahead keeps rng_re low in reset and for the cycle after a flush.
        rng_re_d = fill_en_d && (level_d != PTR_W'(DEPTH)) && !flush;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fill_en_q  <= 1'b1;
            blocking_q <= 1'b0;
            uf_q       <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            rng_re_q   <= 1'b0;
            rng_we_q   <= 1'b0;
            rng_di_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fill_en_q  <= fill_en_d;
            blocking_q <= blocking_d;
            uf_q       <= uf_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            rng_re_q   <= rng_re_d;
            rng_we_q   <= rng_we_d;
            rng_di_q   <= rng_di_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q[AW-1:0]] <= rng_do_i;
    end
endmodule

// File: tb/tb_iomem_rng_fifo.sv
// Directed bench for iomem_rng_fifo: fill, drain, underflow, blocking timeout, push/pop balance, seed and flush.
// Define RNGFIFO_HEALTH_EN for both DUT and bench to also exercise the repetition check.
module tb_iomem_rng_fifo;
    localparam logic [31:0] BASE    = 32'h0300_1000;
    localparam int          TIMEOUT = 255;
    localparam logic [31:0] A_DATA  = BASE + 32'h0;
    localparam logic [31:0] A_STAT  = BASE + 32'h4;
    localparam logic [31:0] A_CTRL  = BASE + 32'h8;
    localparam logic [31:0] A_SEED  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rng_re, rng_we, rng_wait, stuck;
    logic [31:0] rng_di, rng_do, rng_cnt, rd;
    int          cyc;
    int          n_tests = 0;
    int          n_fail  = 0;

    iomem_rng_fifo_if bus ();

    iomem_rng_fifo #(.BASE_ADDR(BASE), .DATA_W(32), .DEPTH(16), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rng_re_o   (rng_re),
        .rng_we_o   (rng_we),
        .rng_di_o   (rng_di),
        .rng_do_i   (rng_do),
        .rng_wait_i (rng_wait)
    );

    always #5 clk = ~clk;

    // Counting RNG: presents 1, 2, 3, ... and advances on every accepted read.
    always @(posedge clk or posedge rst) begin
        if (rst)
            rng_cnt <= 32'd1;
        else if (rng_re && !rng_wait)
            rng_cnt <= rng_cnt + 32'd1;
    end
    assign rng_do = stuck ? 32'h5 : rng_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transaction started at a negedge; returns read data and cycles until ready.
    task automatic access(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int cycles);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = addr;
        bus.iomem_wstrb = strb;
        bus.iomem_wdata = wdata;
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!bus.iomem_ready && cycles < 400);
        check("ready_seen", 32'(bus.iomem_ready), 32'd1);
        rdata = bus.iomem_rdata;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        int          c;
        access(addr, 4'h0, 32'h0, d, c);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
        logic [31:0] d;
        int          c;
        access(addr, strb, data, d, c);
    endtask

    task automatic rng_run(input int n);
        rng_wait = 1'b0;
        repeat (n) @(negedge clk);
        rng_wait = 1'b1;
    endtask

    initial begin
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_addr  = 32'h0;
        bus.iomem_wdata = 32'h0;
        rng_wait = 1'b0;
        stuck    = 1'b0;

        #2;
        check("rst_ready", 32'(bus.iomem_ready), 32'd0);
        check("rst_rdata", bus.iomem_rdata, 32'h0);
        check("rst_rng_re", 32'(rng_re), 32'd0);
        check("rst_rng_we", 32'(rng_we), 32'd0);
        check("rst_rng_di", rng_di, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        bus.iomem_addr  = BASE + 32'h10;
        bus.iomem_valid = 1'b1;
        #1 check("sel_out_of_range", 32'(bus.iomem_sel), 32'd0);
        bus.iomem_addr = A_SEED;
        #1 check("sel_in_range", 32'(bus.iomem_sel), 32'd1);
        bus.iomem_valid = 1'b0;

        // Fill to full with words 1..16
        repeat (20) @(negedge clk);
        check("full_rng_re", 32'(rng_re), 32'd0);
        rd_chk("status_full", A_STAT, 32'h0000_0210);

        // Drain non-blocking, then underflow
        wr(A_CTRL, 4'h1, 32'h0);
        for (int i = 1; i <= 16; i++)
            rd_chk($sformatf("drain_%0d", i), A_DATA, 32'(i));
        rd_chk("underflow_data", A_DATA, 32'hFFFF_FFFF);
        rd_chk("status_underflow", A_STAT, 32'h0000_0500);
        rd_chk("ctrl_readback", A_CTRL, 32'h0);
        wr(A_CTRL, 4'h1, 32'h8);
        rd_chk("status_uf_clear", A_STAT, 32'h0000_0100);

        // Blocking read times out
        wr(A_CTRL, 4'h1, 32'h2);
        access(A_DATA, 4'h0, 32'h0, rd, cyc);
        check("blk_timeout_data", rd, 32'hFFFF_FFFF);
        check("blk_timeout_cycles", 32'(cyc), 32'(TIMEOUT + 2));
        rd_chk("status_blk_uf", A_STAT, 32'h0000_0500);
        wr(A_CTRL, 4'h1, 32'hA);

        // Blocking read satisfied by a word pushed at cycle 5 (word 17)
        rng_wait = 1'b1;
        wr(A_CTRL, 4'h1, 32'h3);
        fork
            access(A_DATA, 4'h0, 32'h0, rd, cyc);
            begin
                repeat (4) @(posedge clk);
                @(negedge clk) rng_wait = 1'b0;
                @(negedge clk) rng_wait = 1'b1;
            end
        join
        check("blk_word_data", rd, 32'd17);
        check("blk_word_cycles", 32'(cyc), 32'd6);

        // Level 4 (18..21), then pop while pushing on the same edge
        wr(A_CTRL, 4'h1, 32'h1);
        rng_run(4);
        rd_chk("status_level4", A_STAT, 32'h0000_0004);
        for (int i = 0; i < 8; i++) begin
            bus.iomem_valid = 1'b1;
            bus.iomem_addr  = A_DATA;
            bus.iomem_wstrb = 4'h0;
            rng_wait        = 1'b0;
            @(negedge clk);
            rng_wait = 1'b1;
            check($sformatf("pushpop_ready_%0d", i), 32'(bus.iomem_ready), 32'd1);
            check($sformatf("pushpop_data_%0d", i), bus.iomem_rdata, 32'(18 + i));
            bus.iomem_valid = 1'b0;
            @(negedge clk);
        end
        rd_chk("status_level_kept", A_STAT, 32'h0000_0004);
        wr(A_CTRL, 4'h1, 32'h0);
        for (int i = 0; i < 4; i++)
            rd_chk($sformatf("pushpop_tail_%0d", i), A_DATA, 32'(26 + i));

        // Seed write mid-fill (words 30..32 buffered)
        wr(A_CTRL, 4'h1, 32'h1);
        rng_run(3);
        rd_chk("status_level3", A_STAT, 32'h0000_0003);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = A_SEED;
        bus.iomem_wstrb = 4'hF;
        bus.iomem_wdata = 32'hDEAD_BEEF;
        rng_wait        = 1'b0;
        @(negedge clk);
        rng_wait = 1'b1;
        check("seed_ready", 32'(bus.iomem_ready), 32'd1);
        check("seed_we_pulse", 32'(rng_we), 32'd1);
        check("seed_di", rng_di, 32'hDEAD_BEEF);
        check("seed_re_paused", 32'(rng_re), 32'd0);
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        @(negedge clk);
        check("seed_we_single", 32'(rng_we), 32'd0);
        rd_chk("status_after_seed", A_STAT, 32'h0000_0100);
        wr(A_SEED, 4'h3, 32'h1234_5678);
        check("seed_masked", rng_di, 32'h0000_5678);
        rd_chk("seed_reads_zero", A_SEED, 32'h0);
        wr(A_STAT, 4'hF, 32'hFFFF_FFFF);
        rd_chk("status_ro", A_STAT, 32'h0000_0100);
        wr(A_CTRL, 4'h2, 32'h0);
        rd_chk("ctrl_byte0_only", A_CTRL, 32'h1);

        // CTRL flush bit
        rng_run(3);
        rd_chk("status_pre_flush", A_STAT, 32'h0000_0003);
        wr(A_CTRL, 4'h1, 32'h5);
        rd_chk("status_flushed", A_STAT, 32'h0000_0100);
        rd_chk("ctrl_flush_self_clear", A_CTRL, 32'h1);

`ifdef RNGFIFO_HEALTH_EN
        // Stuck RNG: one word pushed, then each repeat counted up to saturation
        stuck = 1'b1;
        wr(A_CTRL, 4'h1, 32'hD);
        @(negedge clk);
        rng_run(10);
        rd_chk("health_rep9", A_STAT, 32'h0000_9001);
        rng_run(300);
        rd_chk("health_saturate", A_STAT, 32'h000F_F001);
        wr(A_CTRL, 4'h1, 32'h9);
        rd_chk("health_clear", A_STAT, 32'h0000_0001);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
